// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared state encoding and default sizing for the memory access unit
package mem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, FINISH} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_TIMEOUT_CYC = 15;
endpackage

// File: rtl/mem_access_unit_timer.sv
// access_timer: saturating wait-cycle counter that flags the last permitted wait cycle
module access_timer
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != CW'(TIMEOUT_CYC)) count <= count + CW'(1);
  // high in the cycle whose increment makes the count reach TIMEOUT_CYC
  assign expired = en && (count >= CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR pair with a handshaked, timeout-guarded memory access sequencer
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  state_t state;
  logic tmr_clr, tmr_en, tmr_exp;
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];
  assign tmr_clr = (state == IDLE) && (rd_req || wr_req);
  assign tmr_en = (state == RD_WAIT) || (state == WR_WAIT);
  assign mem_addr = mar_q;
  assign mem_wdata = mdr_q;
  access_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr(tmr_clr),
    .en(tmr_en),
    .expired(tmr_exp)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mar_q <= '0;
      mdr_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mar_in) mar_q <= bus_in[ADDR_W-1:0];
          if (mdr_in) mdr_q <= bus_in;
          if (rd_req || wr_req) begin
            err <= 1'b0;
            busy <= 1'b1;
            mem_rd_en <= rd_req;
            mem_wr_en <= !rd_req;
            state <= rd_req ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT, WR_WAIT:
          if (mem_ack || tmr_exp) begin
            // an ack on the expiry cycle still counts as a successful access
            if (state == RD_WAIT && mem_ack) mdr_q <= mem_rdata;
            err <= !mem_ack;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done <= 1'b1;
            state <= FINISH;
          end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven accesses with a scoreboard plus reset and idle-ack sequences
module tb_mem_access_unit;
  localparam int T = 15;
  logic        clock, reset;
  logic [31:0] bus_in, mdr_q, mem_wdata, mem_rdata;
  logic [8:0]  mar_q, mem_addr;
  logic        mar_in, mdr_in, rd_req, wr_req, busy, done, err, mem_rd_en, mem_wr_en, mem_ack;
  int checks = 0, failures = 0;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd_req(rd_req), .wr_req(wr_req), .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    int          ack_at;
    logic [8:0]  exp_mar;
    logic [31:0] exp_mdr;
    logic        exp_err;
    int          exp_rd, exp_wr;
  } vec_t;

  typedef struct {
    logic [8:0]  mar;
    logic [31:0] mdr;
    logic        err;
    int          rd_n, wr_n;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    mar_in = 0; mdr_in = 0; rd_req = 0; wr_req = 0; mem_ack = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, got;
    int n, rd_n, wr_n;
    bit seen;
    bus_in = v.addr; mar_in = 1; mdr_in = 0;
    tick;
    bus_in = v.wdata; mar_in = 0; mdr_in = 1; rd_req = v.rd; wr_req = v.wr;
    mem_rdata = v.rdata;
    tick;
    e.mar = v.exp_mar; e.mdr = v.exp_mdr; e.err = v.exp_err; e.rd_n = v.exp_rd; e.wr_n = v.exp_wr;
    sb.push_back(e);
    // hammer the loads and requests during the access; all must be ignored
    bus_in = 32'h0; mar_in = 1; mdr_in = 1; rd_req = 1; wr_req = 1;
    check($sformatf("v%0d_err_cleared", idx), err, 0);
    n = 0; rd_n = 0; wr_n = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (mem_rd_en) rd_n++;
      if (mem_wr_en) begin
        wr_n++;
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_mar);
        check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
      end
      if (mem_rd_en || mem_wr_en) n++;
      mem_ack = (mem_rd_en || mem_wr_en) && (n == v.ack_at);
      tick;
    end
    idle_inputs();
    if (!seen) check($sformatf("v%0d_done_seen", idx), 0, 1);
    else if (sb.size() == 0) check($sformatf("v%0d_sb_empty", idx), 0, 1);
    else begin
      got = sb.pop_front();
      check($sformatf("v%0d_mdr", idx), mdr_q, got.mdr);
      check($sformatf("v%0d_mar", idx), mar_q, got.mar);
      check($sformatf("v%0d_err", idx), err, got.err);
      check($sformatf("v%0d_rd_cycles", idx), rd_n, got.rd_n);
      check($sformatf("v%0d_wr_cycles", idx), wr_n, got.wr_n);
      check($sformatf("v%0d_busy_finish", idx), busy, 1);
    end
    tick;
    check($sformatf("v%0d_done_one_cycle", idx), done, 0);
    check($sformatf("v%0d_busy_idle", idx), busy, 0);
  endtask

  initial begin
    reset = 0; bus_in = 0; mem_rdata = 0;
    idle_inputs();
    vecs[0] = '{1, 0, 32'h010, 32'h0, 32'h12345678, 3, 9'h010, 32'h12345678, 0, 3, 0};
    vecs[1] = '{0, 1, 32'h0FF, 32'hCAFE0001, 32'h0, 2, 9'h0FF, 32'hCAFE0001, 0, 0, 2};
    vecs[2] = '{1, 0, 32'h055, 32'hA5A5A5A5, 32'h99999999, 0, 9'h055, 32'hA5A5A5A5, 1, T, 0};
    vecs[3] = '{1, 0, 32'h100, 32'h0, 32'h0BADF00D, 1, 9'h100, 32'h0BADF00D, 0, 1, 0};
    vecs[4] = '{1, 1, 32'h1C3, 32'h33334444, 32'h11112222, 2, 9'h1C3, 32'h11112222, 0, 2, 0};
    vecs[5] = '{1, 0, 32'h022, 32'h0, 32'h5555AAAA, T, 9'h022, 32'h5555AAAA, 0, T, 0};
    vecs[6] = '{0, 1, 32'h033, 32'h77778888, 32'h0, 0, 9'h033, 32'h77778888, 1, 0, T};
    vecs[7] = '{0, 1, 32'hFFFFFE3C, 32'h01020304, 32'h0, 1, 9'h03C, 32'h01020304, 0, 0, 1};
    tick; tick;
    reset = 1;
    tick;
    check("rst_mdr", mdr_q, 0);
    check("rst_mar", mar_q, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {mem_rd_en, mem_wr_en, done}, 0);
    bus_in = 32'h000001A5; mar_in = 1;
    tick;
    check("load_mar", mar_q, 9'h1A5);
    bus_in = 32'hDEADBEEF; mar_in = 0; mdr_in = 1;
    tick;
    check("load_mdr", mdr_q, 32'hDEADBEEF);
    check("load_mar_kept", mar_q, 9'h1A5);
    mdr_in = 0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick; tick;
    check("idle_ack_mdr", mdr_q, 32'h01020304);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_done", done, 0);
    check("idle_ack_strobes", {mem_rd_en, mem_wr_en}, 0);
    mem_ack = 0;
    wr_req = 1;
    tick;
    wr_req = 0;
    tick;
    check("mid_wr_strobe", mem_wr_en, 1);
    #2 reset = 0;
    #1;
    check("mid_rst_wr_en", mem_wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_regs", {mar_q, mdr_q}, 0);
    @(negedge clock);
    reset = 1;
    tick;
    check("post_rst_outs", {busy, done, err, mem_rd_en, mem_wr_en}, 0);
    check("post_rst_regs", {mar_q, mdr_q}, 0);
    rd_req = 1; mem_rdata = 32'h600DCAFE;
    tick;
    rd_req = 0;
    check("post_rst_rd_strobe", mem_rd_en, 1);
    mem_ack = 1;
    tick;
    mem_ack = 0;
    check("post_rst_done", done, 1);
    check("post_rst_mdr", mdr_q, 32'h600DCAFE);
    check("post_rst_err", err, 0);
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
